// File: rtl/ssd_scan_driver_if.sv
// Bus between the data-formatting logic (master) and the SSD scan driver (slave).
interface ssd_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic                      hex_mode;
  logic                      blank_lz;
  logic [6:0]                seg_out;
  logic                      dp_out;
  logic [NUM_DIGITS-1:0]     an_out;
  logic                      frame_tick;

  modport master (
    output load, digits_in, dp_in, hex_mode, blank_lz,
    input  seg_out, dp_out, an_out, frame_tick
  );

  modport slave (
    input  load, digits_in, dp_in, hex_mode, blank_lz,
    output seg_out, dp_out, an_out, frame_tick
  );
endinterface

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver.
// Round-robin digit scan with per-slot anti-ghost blanking, hex/decimal glyph
// decode, leading-zero suppression and tear-free frame-boundary commit of new
// digit data. All pins are registered (one cycle behind the scan state).
module ssd_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic              CLK,
  input  logic              RST,
  ssd_scan_driver_if.slave  bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

  // scan position
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // displayed and pending digit data
  logic [NUM_DIGITS-1:0][3:0] disp_nib_q, disp_nib_d;
  logic [NUM_DIGITS-1:0]      disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0][3:0] pend_nib_q, pend_nib_d;
  logic [NUM_DIGITS-1:0]      pend_dp_q, pend_dp_d;
  logic                       pend_valid_q, pend_valid_d;

  // registered pins
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  tick_q, tick_d;

  logic                  frame_end;
  logic                  in_win;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  lz_run;

  // Segment codes {g,f,e,d,c,b,a}, active-low. In decimal mode the codes above
  // 9 are reused for glyphs the formatter needs: blank, 'C' and minus.
  function automatic logic [6:0] glyph(input logic [3:0] n, input logic hex);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    if (!hex) begin
      if (n == 4'hA)      g = 7'h7F;
      else if (n == 4'hB) g = 7'h46;
      else if (n >= 4'hC) g = 7'h3F;
    end
    return g;
  endfunction

  // A zero-length blanking window means the anode is lit for the whole slot.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign in_win = 1'b1;
  end else begin : g_blank
    assign in_win = (cnt_q >= BLANK_END);
  end

  assign frame_end = (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);

  // Slot counter and digit index; index advances on every slot wrap.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  // Loads land in the pending buffer; the display copy only changes on the
  // frame-boundary edge. A load in the boundary cycle itself re-arms pending
  // after the commit, so it waits for the following boundary.
  always_comb begin
    disp_nib_d   = disp_nib_q;
    disp_dp_d    = disp_dp_q;
    pend_nib_d   = pend_nib_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    if (frame_end && pend_valid_q) begin
      disp_nib_d   = pend_nib_q;
      disp_dp_d    = pend_dp_q;
      pend_valid_d = 1'b0;
    end
    if (bus.load) begin
      pend_nib_d   = bus.digits_in;
      pend_dp_d    = bus.dp_in;
      pend_valid_d = 1'b1;
    end
  end

  // Leading-zero mask: walk from the most significant digit down while both
  // nibble and decimal point are zero. Digit 0 always stays visible.
  always_comb begin
    lz_blank = '0;
    lz_run   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lz_run      = lz_run & (disp_nib_q[k] == 4'd0) & ~disp_dp_q[k];
      lz_blank[k] = lz_run & (k != 0);
    end
  end

  // Next pin values from the current scan position and display data.
  always_comb begin
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    an_d   = '1;
    tick_d = frame_end;
    if (in_win) begin
      an_d[idx_q] = 1'b0;
      if (!(bus.blank_lz && lz_blank[idx_q])) begin
        seg_d = glyph(disp_nib_q[idx_q], bus.hex_mode);
        dp_d  = ~disp_dp_q[idx_q];
      end
    end
  end

  // Scan and buffer state; reset drops any pending load.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_nib_q   <= '0;
      disp_dp_q    <= '0;
      pend_nib_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_nib_q   <= disp_nib_d;
      disp_dp_q    <= disp_dp_d;
      pend_nib_q   <= pend_nib_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  // Output registers; reset darkens the display immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
      an_q   <= '1;
      tick_q <= 1'b0;
    end else begin
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
      tick_q <= tick_d;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dp_out     = dp_q;
  assign bus.an_out     = an_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Time-multiplexed driver for a common-anode seven-segment display (SSD) bank with a parametrised number of digits. It holds one nibble plus one decimal point per digit and decodes each nibble to active-low cathodes in either hex or decimal/special-glyph mode. Digits are scanned round-robin at a programmable rate, with anti-ghosting blanking, optional leading-zero suppression, and a tear-free frame-boundary update. The block sits between the data-formatting logic (BCD conversion, sign/unit insertion) and the board's SSD pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 100000, clock cycles per digit slot; minimum 2.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must satisfy 0 <= BLANK_CYCLES < REFRESH_DIV.
- CLK  input  1  system clock; the only clock.
- RST  input  1  asynchronous, active-high reset.
- load  input  1  one-cycle strobe; captures digits_in and dp_in into the pending buffer.
- digits_in  input  4*NUM_DIGITS  nibble per digit; digit 0 is bits [3:0] and is the least significant (rightmost) digit.
- dp_in  input  NUM_DIGITS  decimal point per digit; 1 = lit.
- hex_mode  input  1  1 = hex glyphs; 0 = decimal/special glyphs.
- blank_lz  input  1  1 = suppress leading zeros.
- seg_out  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp_out  output  1  decimal-point cathode, active-low.
- an_out  output  NUM_DIGITS  anodes, active-low, at most one low at a time.
- frame_tick  output  1  one-cycle pulse at each frame boundary.

## Operation
- **Counters.**
  - cnt runs 0..REFRESH_DIV-1. When cnt = REFRESH_DIV-1 it wraps to 0 and idx advances.
  - idx runs 0..NUM_DIGITS-1 and wraps to 0 after NUM_DIGITS-1.
  - The frame boundary is the cycle where cnt = REFRESH_DIV-1 and idx = NUM_DIGITS-1.
- **Buffering.**
  - load = 1 writes digits_in and dp_in into the pending registers and sets pend_valid. The last load before a boundary wins.
  - At the frame boundary edge, if pend_valid = 1, the pending registers are copied to the display registers and pend_valid is cleared.
  - A load in the boundary cycle itself goes to pending only and commits at the next boundary.
  - The display registers never change mid-frame.
- **Glyphs, hex mode.** 0..F map to 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, bit6 = g).
- **Glyphs, decimal mode.**
  - 0..9 use the same codes as hex mode.
  - A decodes to blank (7F).
  - B decodes to 'C' (46).
  - C..F decode to minus (3F).
- **Leading-zero blanking.**
  - With blank_lz = 1, digit k > 0 is blanked (seg 7F, dp off) if display nibbles k..NUM_DIGITS-1 are all 0 and dp bits k..NUM_DIGITS-1 are all 0.
  - Digit 0 is never blanked by this rule.
- hex_mode and blank_lz are sampled live every cycle, not buffered.
- **Anodes.** an_out[k] = 0 only when k = idx and cnt >= BLANK_CYCLES. During the blanking window all anodes are 1 and seg_out/dp_out are 1s.

## Timing
- **Reset values:**
  - seg_out = 7'h7F, dp_out = 1, an_out = all 1s, frame_tick = 0.
  - cnt = 0, idx = 0.
  - Display and pending registers = 0, pend_valid = 0.
- **Reset mid-operation** aborts the scan immediately: outputs go to reset values asynchronously, and any pending load is discarded.
- **Output registration.** seg_out, dp_out, an_out and frame_tick are registered. Each reflects the cnt/idx/display state of the previous cycle (latency 1).
- frame_tick is high for exactly the one cycle after the boundary edge. It pulses every frame whether or not a commit occurred.
- **Display latency.** A load becomes visible no earlier than the first slot of the next frame, plus the 1-cycle output latency. Worst case is one full frame, NUM_DIGITS*REFRESH_DIV cycles.
- **NUM_DIGITS = 1:** idx stays 0, and every slot wrap is a frame boundary.
- **BLANK_CYCLES = 0:** the anode is active for the whole slot.

## Test plan
Benches use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.

1. **Reset and scan order.**
   - Stimulus: RST high, then release, with no load.
   - Required: outputs hold reset values while RST is high. an_out then walks E,D,B,7, each low for 6 of every 8 cycles, all-ones during the 2 blank cycles. seg_out = 40 during lit windows. frame_tick pulses every 32 cycles.
2. **Hex and decimal decode.**
   - Stimulus: load digits_in = 16'hFB3A with hex_mode = 1, then the same value with hex_mode = 0.
   - Required, hex mode: after commit, digits 0..3 show 08,30,03,0E.
   - Required, decimal mode: digits 0..3 show 7F,30,46,3F.
3. **Tear-free update.**
   - Stimulus: load 16'h1234 while idx = 1, then load 16'h5678 while idx = 2 of the same frame.
   - Required: the current frame finishes with the old data. The next frame shows 5678; 1234 is never displayed.
4. **Boundary-cycle load.**
   - Stimulus: load 16'h0009 exactly on the boundary cycle.
   - Required: the following frame still shows the previous data. 0009 appears one frame later.
5. **Leading-zero blanking.**
   - Stimulus: blank_lz = 1, load 16'h0050 with dp_in = 0, then load 16'h0000.
   - Required, 0050: digits 3 and 2 read 7F, digits 1 and 0 read 12 and 40.
   - Required, 0000: only digit 0 shows 40.
   - Required, 0050 with dp_in = 4'b0100: digit 2 shows 40 with dp_out = 0.
6. **Reset mid-operation.**
   - Stimulus: assert RST during idx = 2, cnt = 5, with a load pending.
   - Required: an_out = F and seg_out = 7F asynchronously. After release, the scan restarts at idx 0 showing 40, and the pending data is lost.
